// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//
// CPU-side strobe bus between the VeriRISC controller/datapath and the
// memory responder.
//
//   addr      CPU address, sampled on every edge where a strobe is high
//   data_in   write data from the accumulator
//   mem_rd    read strobe (level; may be held for a burst)
//   mem_wr    write strobe (single-cycle pulse)
//   data_out  registered read data
//   rd_valid  high the cycle after an accepted read
//   wr_ack    one-cycle pulse the cycle after an accepted write
//
// The master modport is the CPU side and the slave modport is the responder.
// ---------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data_in;
    logic              mem_rd;
    logic              mem_wr;
    logic [DWIDTH-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;

    modport master (
        output addr,
        output data_in,
        output mem_rd,
        output mem_wr,
        input  data_out,
        input  rd_valid,
        input  wr_ack
    );

    modport slave (
        input  addr,
        input  data_in,
        input  mem_rd,
        input  mem_wr,
        output data_out,
        output rd_valid,
        output wr_ack
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the VeriRISC mem_rd / mem_wr strobes. Services
// the strobes against an internal 2**AWIDTH x DWIDTH register file, returns
// registered read data and write acknowledgements, flags protocol misuse in
// a sticky error bit and counts read bursts and accepted writes.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-low reset (memory contents are kept)
//   bus        CPU strobe bus (slave side): addr, data_in, mem_rd, mem_wr,
//              data_out, rd_valid, wr_ack
//   load_en    preload write enable (test / boot)
//   load_addr  preload address
//   load_data  preload data
//   err_clr    synchronous clear of err (a new violation wins)
//   err        sticky protocol-error flag
//   rd_bursts  saturating count of read bursts
//   wr_count   saturating count of accepted CPU writes
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    input  logic              load_en,
    input  logic [AWIDTH-1:0] load_addr,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              err_clr,
    output logic              err,
    output logic [CWIDTH-1:0] rd_bursts,
    output logic [CWIDTH-1:0] wr_count
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int NCNT  = 2;   // 0: read bursts, 1: accepted writes

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DWIDTH-1:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Registered state and outputs
    // -----------------------------------------------------------------------
    state_t            state_reg;
    logic [DWIDTH-1:0] data_out_reg;
    logic              rd_valid_reg;
    logic              wr_ack_reg;
    logic              err_reg;
    logic [AWIDTH-1:0] last_addr_reg;   // address of the previous read edge

    // -----------------------------------------------------------------------
    // Protocol decode for the current edge
    // -----------------------------------------------------------------------
    logic collision;        // both strobes high: read wins
    logic wr_held;          // second consecutive write strobe
    logic rd_addr_moved;    // address changed inside a running burst
    logic load_conflict;    // preload coincides with a CPU strobe
    logic violation;
    logic wr_accept;
    logic new_burst;
    logic err_next;
    logic [NCNT-1:0] cnt_inc;

    always_comb begin
        collision     = bus.mem_rd && bus.mem_wr;
        wr_held       = (state_reg == S_WRITE) && bus.mem_wr;
        rd_addr_moved = (state_reg == S_READ) && bus.mem_rd
                        && (bus.addr != last_addr_reg);
        load_conflict = load_en && (bus.mem_rd || bus.mem_wr);
        violation     = collision || wr_held || rd_addr_moved || load_conflict;

        // A write lands only when nothing else claims the cycle: no read,
        // no preload and not the tail of a held write strobe.
        wr_accept     = bus.mem_wr && !bus.mem_rd && !load_en
                        && (state_reg != S_WRITE);

        // Any read edge not preceded by a read edge opens a new burst; this
        // includes the first read after reset, since reset returns to idle.
        new_burst     = bus.mem_rd && (state_reg != S_READ);

        // Setting beats clearing when both happen in the same cycle.
        if (violation) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end

        cnt_inc[0] = new_burst;
        cnt_inc[1] = wr_accept;
    end

    // -----------------------------------------------------------------------
    // Memory write port. Preload and CPU write never coincide because a
    // preload drops the CPU write. Gated by reset so nothing is written on
    // an edge where reset is asserted; the array itself is never cleared.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (load_en) begin
                mem[load_addr] <= load_data;
            end else if (wr_accept) begin
                mem[bus.addr] <= bus.data_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Strobe FSM with registered outputs. The read samples the array before
    // any same-edge write, so a write followed by a read of the same address
    // on the next edge sees the new data without a bypass path.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            data_out_reg  <= '0;
            rd_valid_reg  <= 1'b0;
            wr_ack_reg    <= 1'b0;
            err_reg       <= 1'b0;
            last_addr_reg <= '0;
        end else begin
            err_reg      <= err_next;
            rd_valid_reg <= bus.mem_rd;
            wr_ack_reg   <= wr_accept;

            if (bus.mem_rd) begin
                data_out_reg  <= mem[bus.addr];
                last_addr_reg <= bus.addr;
            end

            case (state_reg)
                S_IDLE: begin
                    if (bus.mem_rd) begin
                        state_reg <= S_READ;
                    end else if (bus.mem_wr) begin
                        state_reg <= S_WRITE;
                    end
                end
                S_READ: begin
                    // Held read stays in the same burst.
                    if (bus.mem_rd) begin
                        state_reg <= S_READ;
                    end else if (bus.mem_wr) begin
                        state_reg <= S_WRITE;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    // A read (even alongside a stray write) always starts a
                    // new burst; a repeated write strobe just lingers here
                    // and is rejected by wr_accept.
                    if (bus.mem_rd) begin
                        state_reg <= S_READ;
                    end else if (bus.mem_wr) begin
                        state_reg <= S_WRITE;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Saturating transaction counters
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : g_cnt
            logic [CWIDTH-1:0] count_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    count_reg <= '0;
                end else if (cnt_inc[gi] && (count_reg != {CWIDTH{1'b1}})) begin
                    count_reg <= count_reg + CWIDTH'(1);
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign bus.data_out = data_out_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.wr_ack   = wr_ack_reg;
    assign err          = err_reg;
    assign rd_bursts    = g_cnt[0].count_reg;
    assign wr_count     = g_cnt[1].count_reg;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. A behavioural model tracks memory
// contents, the previous cycle's strobes and the expected outputs; each test
// task drives the design and compares outputs inline against the model or
// against literal values.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          err_clr;
    logic          err;
    logic [CW-1:0] rd_bursts;
    logic [CW-1:0] wr_count;

    mem_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .err_clr   (err_clr),
        .err       (err),
        .rd_bursts (rd_bursts),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model
    logic [DW-1:0] mdl_mem [32];
    logic [DW-1:0] exp_data;
    logic          exp_rd_valid;
    logic          exp_wr_ack;
    logic          exp_err;
    int            exp_bursts;
    int            exp_wrc;
    logic          prev_rd;
    logic          prev_wr;
    logic [AW-1:0] prev_addr;

    task automatic model_reset();
        exp_data     = '0;
        exp_rd_valid = 1'b0;
        exp_wr_ack   = 1'b0;
        exp_err      = 1'b0;
        exp_bursts   = 0;
        exp_wrc      = 0;
        prev_rd      = 1'b0;
        prev_wr      = 1'b0;
        prev_addr    = '0;
    endtask

    // One clock: drive inputs after the falling edge, update the model from
    // the strobe rules, then let the rising edge happen and settle.
    task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] din, input logic ld,
                        input logic [AW-1:0] la, input logic [DW-1:0] ldat,
                        input logic clr);
        logic viol;
        logic wr_ok;
        @(negedge clk);
        bus.mem_rd  = rd;
        bus.mem_wr  = wr;
        bus.addr    = a;
        bus.data_in = din;
        load_en     = ld;
        load_addr   = la;
        load_data   = ldat;
        err_clr     = clr;

        // A write is "held" when the previous edge was a lone write strobe.
        viol  = (rd && wr) || (rd && prev_rd && (a != prev_addr))
                || (wr && !rd && prev_wr && !prev_rd) || (ld && (rd || wr));
        wr_ok = wr && !rd && !ld && !(prev_wr && !prev_rd);

        if (rd) exp_data = mdl_mem[a];
        exp_rd_valid = rd;
        exp_wr_ack   = wr_ok;
        if (rd && !prev_rd && exp_bursts < 255) exp_bursts++;
        if (wr_ok && exp_wrc < 255) exp_wrc++;
        if (viol) exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
        if (ld) mdl_mem[la] = ldat;
        else if (wr_ok) mdl_mem[a] = din;

        prev_rd = rd;
        prev_wr = wr;
        if (rd) prev_addr = a;

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b0, 1'b0, '0, '0, 1'b1, a, d, 1'b0);
    endtask

    task automatic clear_err();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset       = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        err_clr     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", bus.data_out); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); else n_pass++;
        n_checks++; if (bus.wr_ack !== 1'b0) $display("FAIL reset_wr_ack: got %b want 0", bus.wr_ack); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (rd_bursts !== 8'd0) $display("FAIL reset_rd_bursts: got %0d want 0", rd_bursts); else n_pass++;
        n_checks++; if (wr_count !== 8'd0) $display("FAIL reset_wr_count: got %0d want 0", wr_count); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) preload(AW'(i), DW'($urandom_range(0, 255)));
        n_checks++; if (wr_count !== 8'd0) $display("FAIL preload_not_counted: got %0d want 0", wr_count); else n_pass++;
        $display("test_reset: done");
    endtask

    task automatic test_read_burst();
        int base;
        preload(5'd5, 8'hA5);
        base = exp_bursts;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 5'd5, '0, 1'b0, '0, '0, 1'b0);
            n_checks++; if (bus.data_out !== 8'hA5) $display("FAIL burst_data[%0d]: got %h want a5", i, bus.data_out); else n_pass++;
            n_checks++; if (bus.rd_valid !== 1'b1) $display("FAIL burst_rd_valid[%0d]: got %b want 1", i, bus.rd_valid); else n_pass++;
        end
        n_checks++; if (rd_bursts !== CW'(base + 1)) $display("FAIL burst_count: got %0d want %0d", rd_bursts, base + 1); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL burst_err: got %b want 0", err); else n_pass++;
        idle();
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.data_out !== 8'hA5) $display("FAIL burst_end: got rd_valid=%b data=%h want 0/a5", bus.rd_valid, bus.data_out); else n_pass++;
        $display("test_read_burst: done");
    endtask

    task automatic test_write_read();
        int base;
        base = exp_wrc;
        step(1'b0, 1'b1, 5'd3, 8'h3C, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.wr_ack !== 1'b1) $display("FAIL wr_ack_pulse: got %b want 1", bus.wr_ack); else n_pass++;
        step(1'b1, 1'b0, 5'd3, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.wr_ack !== 1'b0) $display("FAIL wr_ack_single: got %b want 0", bus.wr_ack); else n_pass++;
        n_checks++; if (bus.data_out !== 8'h3C) $display("FAIL wr_readback: got %h want 3c", bus.data_out); else n_pass++;
        n_checks++; if (wr_count !== CW'(base + 1)) $display("FAIL wr_count: got %0d want %0d", wr_count, base + 1); else n_pass++;
        idle();
        $display("test_write_read: done");
    endtask

    task automatic test_collision();
        int base;
        preload(5'd7, 8'h11);
        base = exp_wrc;
        step(1'b1, 1'b1, 5'd7, 8'hFF, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.data_out !== 8'h11) $display("FAIL coll_data: got %h want 11", bus.data_out); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL coll_err: got %b want 1", err); else n_pass++;
        n_checks++; if (bus.wr_ack !== 1'b0) $display("FAIL coll_wr_ack: got %b want 0", bus.wr_ack); else n_pass++;
        n_checks++; if (wr_count !== CW'(base)) $display("FAIL coll_wr_count: got %0d want %0d", wr_count, base); else n_pass++;
        step(1'b1, 1'b0, 5'd7, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.data_out !== 8'h11) $display("FAIL coll_mem_kept: got %h want 11", bus.data_out); else n_pass++;
        clear_err();
        n_checks++; if (err !== 1'b0) $display("FAIL coll_err_clr: got %b want 0", err); else n_pass++;
        $display("test_collision: done");
    endtask

    task automatic test_write_held();
        int base;
        base = exp_wrc;
        step(1'b0, 1'b1, 5'd2, 8'h5A, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.wr_ack !== 1'b1 || err !== 1'b0) $display("FAIL held_first: got ack=%b err=%b want 1/0", bus.wr_ack, err); else n_pass++;
        step(1'b0, 1'b1, 5'd2, 8'h77, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.wr_ack !== 1'b0) $display("FAIL held_second_ack: got %b want 0", bus.wr_ack); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL held_err: got %b want 1", err); else n_pass++;
        n_checks++; if (wr_count !== CW'(base + 1)) $display("FAIL held_wr_count: got %0d want %0d", wr_count, base + 1); else n_pass++;
        step(1'b1, 1'b0, 5'd2, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.data_out !== 8'h5A) $display("FAIL held_mem: got %h want 5a", bus.data_out); else n_pass++;
        // Clear and violation in the same cycle: the set must win.
        step(1'b1, 1'b1, 5'd2, 8'h00, 1'b0, '0, '0, 1'b1);
        n_checks++; if (err !== 1'b1) $display("FAIL set_beats_clr: got %b want 1", err); else n_pass++;
        clear_err();
        $display("test_write_held: done");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, AW'($urandom_range(0, 31)), '0, 1'b0, '0, '0, 1'b0);
            idle();
        end
        n_checks++; if (rd_bursts !== 8'd255) $display("FAIL burst_saturate: got %0d want 255", rd_bursts); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL sat_err: got %b want 0", err); else n_pass++;
        step(1'b1, 1'b0, 5'd4, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (err !== 1'b0) $display("FAIL addr_move_pre: got %b want 0", err); else n_pass++;
        step(1'b1, 1'b0, 5'd9, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (err !== 1'b1) $display("FAIL addr_move_err: got %b want 1", err); else n_pass++;
        n_checks++; if (bus.data_out !== mdl_mem[9]) $display("FAIL addr_move_data: got %h want %h", bus.data_out, mdl_mem[9]); else n_pass++;
        step(1'b1, 1'b0, 5'd9, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (rd_bursts !== 8'd255) $display("FAIL burst_hold_sat: got %0d want 255", rd_bursts); else n_pass++;
        clear_err();
        $display("test_saturation: done");
    endtask

    task automatic test_random();
        logic          rd, wr, ld, clr;
        logic [AW-1:0] a;
        int            r;
        int            errs_before;
        errs_before = n_checks - n_pass;
        a = '0;
        for (int i = 0; i < 400; i++) begin
            r   = int'($urandom_range(0, 7));
            rd  = (r < 3) || (r == 5);
            wr  = (r == 3) || (r == 4) || (r == 5);
            ld  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 31));
            step(rd, wr, a, DW'($urandom_range(0, 255)), ld,
                 AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)), clr);
            n_checks++; if (bus.data_out !== exp_data) $display("FAIL rnd_data[%0d]: got %h want %h", i, bus.data_out, exp_data); else n_pass++;
            n_checks++; if (bus.rd_valid !== exp_rd_valid) $display("FAIL rnd_rd_valid[%0d]: got %b want %b", i, bus.rd_valid, exp_rd_valid); else n_pass++;
            n_checks++; if (bus.wr_ack !== exp_wr_ack) $display("FAIL rnd_wr_ack[%0d]: got %b want %b", i, bus.wr_ack, exp_wr_ack); else n_pass++;
            n_checks++; if (err !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", i, err, exp_err); else n_pass++;
            n_checks++; if (rd_bursts !== CW'(exp_bursts)) $display("FAIL rnd_bursts[%0d]: got %0d want %0d", i, rd_bursts, exp_bursts); else n_pass++;
            n_checks++; if (wr_count !== CW'(exp_wrc)) $display("FAIL rnd_wr_count[%0d]: got %0d want %0d", i, wr_count, exp_wrc); else n_pass++;
        end
        $display("test_random: 400 cycles, %0d new failures", (n_checks - n_pass) - errs_before);
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] old12;
        logic [DW-1:0] old5;
        old12 = mdl_mem[12];
        old5  = mdl_mem[5];
        step(1'b1, 1'b0, 5'd10, '0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 5'd10, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b1;
        bus.addr    = 5'd12;
        bus.data_in = ~old12;
        reset       = 1'b0;
        #1;
        n_checks++; if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b0 || bus.wr_ack !== 1'b0) $display("FAIL async_rst_bus: got data=%h rv=%b ack=%b want 00/0/0", bus.data_out, bus.rd_valid, bus.wr_ack); else n_pass++;
        n_checks++; if (err !== 1'b0 || rd_bursts !== 8'd0 || wr_count !== 8'd0) $display("FAIL async_rst_status: got err=%b rb=%0d wc=%0d want 0/0/0", err, rd_bursts, wr_count); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.wr_ack !== 1'b0 || wr_count !== 8'd0) $display("FAIL rst_hold: got ack=%b wc=%0d want 0/0", bus.wr_ack, wr_count); else n_pass++;
        @(negedge clk);
        bus.mem_wr = 1'b0;
        reset      = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 5'd12, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.data_out !== old12) $display("FAIL rst_no_write: got %h want %h", bus.data_out, old12); else n_pass++;
        n_checks++; if (rd_bursts !== 8'd1) $display("FAIL rst_new_burst: got %0d want 1", rd_bursts); else n_pass++;
        idle();
        step(1'b1, 1'b0, 5'd5, '0, 1'b0, '0, '0, 1'b0);
        n_checks++; if (bus.data_out !== old5) $display("FAIL rst_mem_kept: got %h want %h", bus.data_out, old5); else n_pass++;
        idle();
        $display("test_reset_mid_burst: done");
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_read();
        test_collision();
        test_write_held();
        test_saturation();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
